prog_loader: RTL and testbench

Byte-stream program loader that fills the processor's 1024 x 9-bit instruction memory. It receives framed bytes over a valid/ready interface, packs them into 9-bit instruction words, and writes those words through a memory write port. It validates the frame with an XOR checksum and holds the processor while a frame is in progress. It is the writer side of the instruction memory that the processor's fetch stage reads.

---
 rtl/prog_loader.sv | 210 +++++++++++++++++++++
 tb/tb_prog_loader.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: byte-stream loader for the 1024 x 9-bit instruction memory.
//
// Accepts framed bytes (SYNC, CNT_HI, CNT_LO, N x {WHI, WLO}, CHK) over a
// valid/ready handshake, packs each WHI/WLO pair into one 9-bit word, and
// writes the words through a registered memory write port. An XOR checksum
// covers every byte between SYNC and CHK. The processor is held for the whole
// frame, including the final DONE/ERR cycle.
//
// Ports:
//   clk1       in   clock, all logic on posedge
//   rst        in   asynchronous active-high reset
//   in_data    in   stream byte
//   in_valid   in   in_data is valid
//   in_ready   out  loader can accept a byte (low only in DONE/ERR)
//   mem_we     out  one-cycle write strobe per word
//   mem_addr   out  write address (BASE_ADDR + word index)
//   mem_wdata  out  write data {WHI[0], WLO}
//   cpu_hold   out  processor must not fetch while high
//   done       out  one-cycle pulse: frame loaded, checksum good
//   err        out  one-cycle pulse: frame rejected
module prog_loader #(
    parameter int         ADDR_W    = 10,
    parameter int         DATA_W    = 9,
    parameter int         BASE_ADDR = 0,
    parameter logic [7:0] SYNC      = 8'hA5
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    // Largest word count that still fits between BASE_ADDR and the top of memory.
    localparam logic [31:0]       N_LIMIT = 32'((2 ** ADDR_W) - BASE_ADDR);
    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CNTH = 3'd1,
        S_CNTL = 3'd2,
        S_WHI  = 3'd3,
        S_WLO  = 3'd4,
        S_CHK  = 3'd5,
        S_DONE = 3'd6,
        S_ERR  = 3'd7
    } state_t;

    // Running frame checksum: plain XOR of the accepted bytes.
    function automatic logic [7:0] f_chk_next(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    state_t            r_state;
    state_t            w_next;
    logic [7:0]        r_acc;
    logic [1:0]        r_cnt_hi;
    logic [9:0]        r_left;
    logic [ADDR_W-1:0] r_waddr;
    logic              r_whi;
    logic              r_in_ready;
    logic              r_cpu_hold;
    logic              r_done;
    logic              r_err;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic              w_accept;
    logic [9:0]        w_n;

    assign w_accept = in_valid && r_in_ready;
    // Word count as seen while the CNT_LO byte is on the bus.
    assign w_n      = {r_cnt_hi, in_data};

    assign in_ready  = r_in_ready;
    assign cpu_hold  = r_cpu_hold;
    assign done      = r_done;
    assign err       = r_err;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    // Next-state decode of the frame parser.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && (in_data == SYNC)) w_next = S_CNTH;
                else                               w_next = S_IDLE;
            end
            S_CNTH: begin
                if (w_accept) begin
                    if (in_data[7:2] != 6'd0) w_next = S_ERR;
                    else                      w_next = S_CNTL;
                end else begin
                    w_next = S_CNTH;
                end
            end
            S_CNTL: begin
                if (w_accept) begin
                    if ({22'd0, w_n} > N_LIMIT) w_next = S_ERR;
                    else if (w_n == 10'd0)      w_next = S_CHK;
                    else                        w_next = S_WHI;
                end else begin
                    w_next = S_CNTL;
                end
            end
            S_WHI: begin
                if (w_accept) begin
                    if (in_data[7:1] != 7'd0) w_next = S_ERR;
                    else                      w_next = S_WLO;
                end else begin
                    w_next = S_WHI;
                end
            end
            S_WLO: begin
                // r_left still counts the word being completed now.
                if (w_accept) begin
                    if (r_left == 10'd1) w_next = S_CHK;
                    else                 w_next = S_WHI;
                end else begin
                    w_next = S_WLO;
                end
            end
            S_CHK: begin
                if (w_accept) begin
                    if (in_data == r_acc) w_next = S_DONE;
                    else                  w_next = S_ERR;
                end else begin
                    w_next = S_CHK;
                end
            end
            S_DONE:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register plus status outputs registered from the next state.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b1;
            r_cpu_hold <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next != S_DONE) && (w_next != S_ERR);
            r_cpu_hold <= (w_next != S_IDLE);
            r_done     <= (w_next == S_DONE);
            r_err      <= (w_next == S_ERR);
        end
    end

    // Frame datapath: checksum, word count, word assembly and the write port.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_acc       <= 8'd0;
            r_cnt_hi    <= 2'd0;
            r_left      <= 10'd0;
            r_waddr     <= BASE;
            r_whi       <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_we <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    S_IDLE: begin
                        if (in_data == SYNC) r_acc <= 8'd0;
                    end
                    S_CNTH: begin
                        r_acc    <= f_chk_next(r_acc, in_data);
                        r_cnt_hi <= in_data[1:0];
                    end
                    S_CNTL: begin
                        r_acc   <= f_chk_next(r_acc, in_data);
                        r_left  <= w_n;
                        r_waddr <= BASE;
                    end
                    S_WHI: begin
                        r_acc <= f_chk_next(r_acc, in_data);
                        r_whi <= in_data[0];
                    end
                    S_WLO: begin
                        r_acc       <= f_chk_next(r_acc, in_data);
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_waddr;
                        r_mem_wdata <= DATA_W'({r_whi, in_data});
                        r_waddr     <= r_waddr + {{(ADDR_W-1){1'b0}}, 1'b1};
                        r_left      <= r_left - 10'd1;
                    end
                    default: begin
                        r_acc <= r_acc;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: two instances (BASE_ADDR 0 and 1020) share clock,
// reset and data; each has its own valid. A frame-position model predicts
// every output on every cycle; directed frames add literal expectations.
module tb_prog_loader;

    logic       clk1 = 1'b0;
    logic       rst  = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       v0 = 1'b0;
    logic       v1 = 1'b0;

    logic       o_rdy  [2];
    logic       o_hold [2];
    logic       o_we   [2];
    logic       o_done [2];
    logic       o_err  [2];
    logic [9:0] o_addr [2];
    logic [8:0] o_wd   [2];

    prog_loader #(.ADDR_W(10), .DATA_W(9), .BASE_ADDR(0), .SYNC(8'hA5)) dut0 (
        .clk1(clk1), .rst(rst), .in_data(in_data), .in_valid(v0),
        .in_ready(o_rdy[0]), .mem_we(o_we[0]), .mem_addr(o_addr[0]),
        .mem_wdata(o_wd[0]), .cpu_hold(o_hold[0]), .done(o_done[0]), .err(o_err[0])
    );

    prog_loader #(.ADDR_W(10), .DATA_W(9), .BASE_ADDR(1020), .SYNC(8'hA5)) dut1 (
        .clk1(clk1), .rst(rst), .in_data(in_data), .in_valid(v1),
        .in_ready(o_rdy[1]), .mem_we(o_we[1]), .mem_addr(o_addr[1]),
        .mem_wdata(o_wd[1]), .cpu_hold(o_hold[1]), .done(o_done[1]), .err(o_err[1])
    );

    always #5 clk1 = ~clk1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit started = 1'b0;

    // ---------------- behavioural model (frame byte position) ----------------
    int         m_pos [2];
    int         m_n   [2];
    logic [7:0] m_acc [2];
    logic [1:0] m_hi  [2];
    logic       m_whi [2];
    logic       m_cool[2];
    logic       e_rdy [2];
    logic       e_hold[2];
    logic       e_we  [2];
    logic       e_done[2];
    logic       e_err [2];
    logic [9:0] e_addr[2];
    logic [8:0] e_wd  [2];

    function automatic int base_of(input int d);
        return (d == 0) ? 0 : 1020;
    endfunction

    task automatic model_reset(input int d);
        m_pos[d] = 0; m_n[d] = 0; m_acc[d] = 8'd0; m_hi[d] = 2'd0;
        m_whi[d] = 1'b0; m_cool[d] = 1'b0;
        e_rdy[d] = 1'b1; e_hold[d] = 1'b0; e_we[d] = 1'b0;
        e_done[d] = 1'b0; e_err[d] = 1'b0; e_addr[d] = 10'd0; e_wd[d] = 9'd0;
    endtask

    task automatic model_end(input int d, input bit ok);
        if (ok) e_done[d] = 1'b1;
        else    e_err[d]  = 1'b1;
        m_cool[d] = 1'b1;
        m_pos[d]  = 0;
    endtask

    task automatic model_step(input int d, input bit a, input logic [7:0] b);
        int k;
        e_we[d] = 1'b0; e_done[d] = 1'b0; e_err[d] = 1'b0;
        if (m_cool[d]) begin
            m_cool[d] = 1'b0;
        end else if (a) begin
            if (m_pos[d] == 0) begin
                if (b == 8'hA5) begin m_pos[d] = 1; m_acc[d] = 8'd0; end
            end else if (m_pos[d] == 1) begin
                m_acc[d] ^= b;
                if (b > 8'd3) model_end(d, 1'b0);
                else begin m_hi[d] = b[1:0]; m_pos[d] = 2; end
            end else if (m_pos[d] == 2) begin
                m_acc[d] ^= b;
                m_n[d] = int'(m_hi[d]) * 256 + int'(b);
                if (m_n[d] > 1024 - base_of(d)) model_end(d, 1'b0);
                else m_pos[d] = 3;
            end else if (m_pos[d] < 3 + 2 * m_n[d]) begin
                m_acc[d] ^= b;
                k = m_pos[d] - 3;
                if (k % 2 == 0) begin
                    if (b > 8'd1) model_end(d, 1'b0);
                    else begin m_whi[d] = b[0]; m_pos[d]++; end
                end else begin
                    e_we[d]   = 1'b1;
                    e_addr[d] = 10'(base_of(d) + k / 2);
                    e_wd[d]   = {m_whi[d], b};
                    m_pos[d]++;
                end
            end else begin
                model_end(d, b == m_acc[d]);
            end
        end
        e_rdy[d]  = !m_cool[d];
        e_hold[d] = (m_pos[d] != 0) || m_cool[d];
    endtask

    initial begin
        model_reset(0);
        model_reset(1);
        forever begin
            @(posedge clk1 or posedge rst);
            if (rst) begin
                model_reset(0);
                model_reset(1);
            end else begin
                cyc++;
                model_step(0, v0 && e_rdy[0], in_data);
                model_step(1, v1 && e_rdy[1], in_data);
            end
        end
    end

    // ---------------- logs used by the literal checks ----------------
    logic [9:0] la0[$], la1[$];
    logic [8:0] ld0[$], ld1[$];
    int         lc0[$];
    int         nd[2], ne[2], nh[2];

    task automatic clr_logs();
        la0.delete(); la1.delete(); ld0.delete(); ld1.delete(); lc0.delete();
        for (int d = 0; d < 2; d++) begin nd[d] = 0; ne[d] = 0; nh[d] = 0; end
    endtask

    // Per-cycle comparison against the model, plus event logging.
    initial begin
        forever begin
            @(negedge clk1);
            if (started) begin
                for (int d = 0; d < 2; d++) begin
                    total++;
                    if (o_rdy[d] !== e_rdy[d] || o_hold[d] !== e_hold[d] || o_we[d] !== e_we[d] ||
                        o_done[d] !== e_done[d] || o_err[d] !== e_err[d] ||
                        (e_we[d] && (o_addr[d] !== e_addr[d] || o_wd[d] !== e_wd[d]))) begin
                        bad++;
                        $display("FAIL cycle_cmp dut%0d t=%0t got rdy=%b hold=%b we=%b a=%0d d=%h dn=%b er=%b want rdy=%b hold=%b we=%b a=%0d d=%h dn=%b er=%b",
                                 d, $time, o_rdy[d], o_hold[d], o_we[d], o_addr[d], o_wd[d], o_done[d], o_err[d],
                                 e_rdy[d], e_hold[d], e_we[d], e_addr[d], e_wd[d], e_done[d], e_err[d]);
                    end
                    if (!rst) begin
                        if (o_done[d] === 1'b1) nd[d]++;
                        if (o_err[d]  === 1'b1) ne[d]++;
                        if (o_hold[d] === 1'b1) nh[d]++;
                    end
                end
                if (!rst && o_we[0] === 1'b1) begin la0.push_back(o_addr[0]); ld0.push_back(o_wd[0]); lc0.push_back(cyc); end
                if (!rst && o_we[1] === 1'b1) begin la1.push_back(o_addr[1]); ld1.push_back(o_wd[1]); end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [7:0] fq[$];
    logic [8:0] ew[$];

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    task automatic set_valid(input int d, input logic v);
        if (d == 0) v0 = v;
        else        v1 = v;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk1);
        #1;
    endtask

    // gap: 0 = full rate, 1 = valid toggles every cycle, 2 = random gaps.
    task automatic send(input int d, input int gap);
        int t;
        for (int i = 0; i < fq.size(); i++) begin
            if (gap == 1 && i > 0) begin set_valid(d, 1'b0); idle(1); end
            if (gap == 2) begin
                set_valid(d, 1'b0);
                idle($urandom_range(0, 2));
            end
            in_data = fq[i];
            set_valid(d, 1'b1);
            t = 0;
            forever begin
                @(negedge clk1);
                if (o_rdy[d] === 1'b1) break;
                t++;
                if (t > 30) begin
                    total++; bad++;
                    $display("FAIL ready_timeout dut%0d got=stuck want=ready", d);
                    break;
                end
            end
            @(posedge clk1);
            #1;
        end
        set_valid(d, 1'b0);
    endtask

    // mode: 1 bad checksum, 2 bad WHI at word badk, 3 bad CNT_HI, else good.
    task automatic build(input int n, input int mode, input int badk);
        logic [9:0] nn;
        logic [7:0] acc, hi, whi, wlo;
        logic [8:0] w;
        fq.delete(); ew.delete();
        nn = n[9:0];
        hi = {6'd0, nn[9:8]};
        if (mode == 3) hi = hi | 8'h04;
        fq.push_back(8'hA5); fq.push_back(hi); fq.push_back(nn[7:0]);
        acc = hi ^ nn[7:0];
        for (int k = 0; k < n; k++) begin
            w   = 9'($urandom_range(0, 511));
            whi = {7'd0, w[8]};
            if (mode == 2 && k == badk) whi = whi | 8'h02;
            wlo = w[7:0];
            fq.push_back(whi); fq.push_back(wlo);
            acc = acc ^ whi ^ wlo;
            ew.push_back(w);
        end
        if (mode == 1) acc = acc ^ 8'h01;
        fq.push_back(acc);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int d, n, mode, badk, nj;
        logic [7:0] j;
        #1 rst = 1'b1;
        #1;
        chk("rst_ready", int'(o_rdy[0]), 1);
        chk("rst_hold",  int'(o_hold[0]), 0);
        chk("rst_we",    int'(o_we[0]), 0);
        chk("rst_addr",  int'(o_addr[0]), 0);
        chk("rst_wdata", int'(o_wd[0]), 0);
        chk("rst_done_err", int'(o_done[0]) + int'(o_err[0]), 0);
        started = 1'b1;
        repeat (2) @(posedge clk1);
        #1 rst = 1'b0;
        idle(2);

        // Normal 2-word frame at full rate.
        clr_logs();
        fq = '{8'hA5, 8'h00, 8'h02, 8'h01, 8'hFF, 8'h00, 8'h55, 8'hA9};
        send(0, 0); idle(4);
        chk("norm_nwr", la0.size(), 2);
        if (la0.size() == 2) begin
            chk("norm_a0", int'(la0[0]), 0);  chk("norm_d0", int'(ld0[0]), 9'h1FF);
            chk("norm_a1", int'(la0[1]), 1);  chk("norm_d1", int'(ld0[1]), 9'h055);
            chk("norm_spacing", lc0[1] - lc0[0], 2);
        end
        chk("norm_done", nd[0], 1);
        chk("norm_err", ne[0], 0);
        chk("norm_hold_cycles", nh[0], 8);

        // Bad checksum: words still written, err instead of done.
        clr_logs();
        fq = '{8'hA5, 8'h00, 8'h02, 8'h01, 8'hFF, 8'h00, 8'h55, 8'hA8};
        send(0, 0); idle(4);
        chk("badchk_nwr", la0.size(), 2);
        chk("badchk_err", ne[0], 1);
        chk("badchk_done", nd[0], 0);

        // CNT_HI with upper bits set is rejected.
        clr_logs();
        fq = '{8'hA5, 8'h04, 8'h01};
        send(0, 0); idle(4);
        chk("cnthi_err", ne[0], 1);
        chk("cnthi_nwr", la0.size(), 0);

        // WHI byte with bits above bit 0 is rejected before any write.
        clr_logs();
        fq = '{8'hA5, 8'h00, 8'h01, 8'h02};
        send(0, 0); idle(4);
        chk("whi_err", ne[0], 1);
        chk("whi_nwr", la0.size(), 0);

        // Leading junk then a zero-length frame.
        clr_logs();
        fq = '{8'h12, 8'h34, 8'hA5, 8'h00, 8'h00, 8'h00};
        send(0, 0); idle(4);
        chk("zero_done", nd[0], 1);
        chk("zero_nwr", la0.size(), 0);
        chk("zero_hold_cycles", nh[0], 4);

        // Gapped valid: same writes, two cycles further apart.
        clr_logs();
        fq = '{8'hA5, 8'h00, 8'h02, 8'h01, 8'hFF, 8'h00, 8'h55, 8'hA9};
        send(0, 1); idle(4);
        chk("gap_nwr", la0.size(), 2);
        if (la0.size() == 2) begin
            chk("gap_d0", int'(ld0[0]), 9'h1FF);
            chk("gap_a1", int'(la0[1]), 1);
            chk("gap_spacing", lc0[1] - lc0[0], 4);
        end
        chk("gap_done", nd[0], 1);

        // Reset right after the first word is written.
        fq = '{8'hA5, 8'h00, 8'h02, 8'h01, 8'hFF};
        send(0, 0);
        chk("pre_rst_we", int'(o_we[0]), 1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_we", int'(o_we[0]), 0);
        chk("mid_rst_hold", int'(o_hold[0]), 0);
        chk("mid_rst_done_err", int'(o_done[0]) + int'(o_err[0]), 0);
        @(posedge clk1);
        #1 rst = 1'b0;
        clr_logs();
        fq = '{8'hA5, 8'h00, 8'h02, 8'h01, 8'hFF, 8'h00, 8'h55, 8'hA9};
        send(0, 0); idle(4);
        chk("after_rst_nwr", la0.size(), 2);
        if (la0.size() == 2) begin
            chk("after_rst_a0", int'(la0[0]), 0);
            chk("after_rst_d1", int'(ld0[1]), 9'h055);
        end
        chk("after_rst_done", nd[0], 1);

        // Top-of-memory window on the BASE_ADDR=1020 instance.
        clr_logs();
        build(4, 0, 0);
        send(1, 0); idle(4);
        chk("top_nwr", la1.size(), 4);
        for (int i = 0; i < 4 && i < la1.size(); i++) begin
            chk("top_addr", int'(la1[i]), 1020 + i);
            chk("top_data", int'(ld1[i]), int'(ew[i]));
        end
        chk("top_done", nd[1], 1);

        clr_logs();
        fq = '{8'hA5, 8'h00, 8'h05};
        send(1, 0); idle(4);
        chk("top_over_err", ne[1], 1);
        chk("top_over_nwr", la1.size(), 0);

        // Random frames, junk and gaps; the per-cycle compare does the checking.
        for (int f = 0; f < 40; f++) begin
            d    = int'($urandom_range(0, 1));
            n    = int'($urandom_range(0, 5));
            mode = int'($urandom_range(0, 7));
            badk = (n > 0) ? int'($urandom_range(0, n - 1)) : 0;
            build(n, mode, badk);
            nj = int'($urandom_range(0, 2));
            for (int i = 0; i < nj; i++) begin
                j = 8'($urandom_range(0, 255));
                if (j == 8'hA5) j = 8'h00;
                fq.push_front(j);
            end
            send(d, int'($urandom_range(0, 2)));
            idle(int'($urandom_range(0, 3)));
        end

        idle(6);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
